div_seq32: RTL and testbench

Sequential signed 32-bit divider that computes quotient and remainder for MIPS `div`. It sits between the A/B operand registers and the HI/LO registers of the multicycle datapath. The control unit pulses `start` and waits for `ready`, then loads `lo` (quotient) into LO and `hi` (remainder) into HI. Division by zero is flagged on `div_zero` so the control unit can raise the exception path.

---
 rtl/div_seq32.sv | 109 ++++++++++
 tb/tb_div_seq32.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq32.sv
// Sequential signed restoring divider for MIPS div: quotient to lo, remainder to hi.
// One quotient bit per cycle, then a sign-fix cycle and a one-cycle ready pulse.
`timescale 1ns/1ps
module div_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             ready,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  // |b| <= 2^(W-1) keeps rem below 2^(W-1), so the shift never loses a bit
  always_comb begin
    a_abs   = a[WIDTH-1] ? -a : a;
    b_abs   = b[WIDTH-1] ? -b : b;
    rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
    fits    = rem_sh >= dvs;
    rem_sub = rem_sh - dvs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (b == '0) begin
              div_zero <= 1'b1;
              ready    <= 1'b1;
              state    <= DONE;
            end else begin
              dvs      <= b_abs;
              quo      <= a_abs;
              rem      <= '0;
              sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r   <= a[WIDTH-1];
              cnt      <= CW'(WIDTH - 1);
              div_zero <= 1'b0;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          rem <= fits ? rem_sub : rem_sh;
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          lo    <= sign_q ? -quo : quo;
          hi    <= sign_r ? -rem : rem;
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq32.sv
// Directed bench for div_seq32: vector table plus zero-divisor,
// reset-abort and ignored-start sequences.
`timescale 1ns/1ps
module tb_div_seq32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        ready;
  logic        div_zero;
  logic        busy;

  int tests = 0;
  int fails = 0;

  div_seq32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .lo       (lo),
    .hi       (hi),
    .ready    (ready),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Start at E0, scramble operands afterwards, return edges until ready.
  task automatic run_div(input logic [31:0] va, input logic [31:0] vb,
                         output int lat);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0000_0003;
    lat = 0;
    while (!ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 33};
    vecs[2] = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 33};
    vecs[3] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 33};
    vecs[4] = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 33};
    vecs[5] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 33};
    vecs[6] = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0,         1'b0, 33};
    vecs[7] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0, 33};

    repeat (2) @(posedge clk);
    #1;
    check("reset_lo", lo, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_dz", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready_drop", i), {31'd0, ready}, 32'd0);
      check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // Zero divisor after a 14/2 result
    run_div(32'd100, 32'd7, lat);
    @(posedge clk);
    run_div(32'd5, 32'd0, lat);
    check("dz_lat", lat, 0);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_busy", {31'd0, busy}, 32'd1);
    check("dz_lo_keep", lo, 32'd14);
    check("dz_hi_keep", hi, 32'd2);
    @(posedge clk);
    #1;
    check("dz_ready_drop", {31'd0, ready}, 32'd0);
    check("dz_sticky", {31'd0, div_zero}, 32'd1);
    check("dz_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    a = 32'd9;
    b = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("dz_clear", {31'd0, div_zero}, 32'd0);
    seen = 0;
    while (!ready && seen < 100) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("dz_next_lo", lo, 32'd4);
    check("dz_next_hi", hi, 32'd1);

    // Reset mid-operation
    @(posedge clk);
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_lo", lo, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    check("rst_no_ready", seen, 0);

    // Fresh run with an ignored second start at E5
    @(negedge clk);
    a = 32'd9;
    b = 32'hFFFFFFFC;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!ready && lat < 100) begin
      if (lat == 4) begin
        a = 32'd50;
        b = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("restart_lat", lat, 33);
    check("restart_lo", lo, 32'hFFFFFFFE);
    check("restart_hi", hi, 32'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    check("restart_no_queue", seen, 0);
    check("restart_hold_lo", lo, 32'hFFFFFFFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
